// File: rtl/cordic_result_drain.sv
// cordic_result_drain
// Reads DEPTH result words out of the shared single-port SRAM after the CORDIC
// engine finishes, and streams them in address order on a valid/ready port.
// A 2-entry output buffer plus one in-flight read absorbs the SRAM latency, so
// full throughput is kept with m_ready held high and nothing is lost under
// backpressure.
//
// Handshake: a word transfers on every rising edge where m_valid and m_ready
// are both 1. m_valid never depends on m_ready, and while m_valid=1 and
// m_ready=0 the presented m_data/m_last stay unchanged.
module cordic_result_drain #(
    parameter int DW    = 16,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          ce_n,
    output logic          we,
    output logic [AW-1:0] addr,
    input  logic [DW-1:0] rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // One extra bit so the counter can reach DEPTH even when DEPTH == 2**AW.
    localparam int             CW        = AW + 1;
    localparam logic [CW-1:0]  LAST_ADDR = CW'(DEPTH - 1);

    logic [1:0]          state;
    logic [1:0]          state_nx;
    logic [CW-1:0]       rd_cnt;
    logic [AW-1:0]       addr_q;
    logic                inflight;
    logic                inflight_last;
    logic [1:0][DW-1:0]  buf_data;
    logic [1:0]          buf_last;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          buf_count;
    logic                pop;
    logic                push;
    logic                issue;
    logic                issue_last;
    logic [2:0]          occ;

    assign m_valid = (buf_count != 2'd0);
    assign pop     = m_valid & m_ready;
    assign push    = inflight;

    // Words that will be held after this edge, before counting a new read.
    // pop implies buf_count >= 1, so this never underflows.
    assign occ        = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == S_FETCH) && (occ < 3'd2);
    assign issue_last = issue && (rd_cnt == LAST_ADDR);

    assign ce_n      = ~issue;
    assign we        = 1'b0;
    assign addr      = issue ? rd_cnt[AW-1:0] : addr_q;
    assign busy      = (state == S_FETCH) || (state == S_FLUSH);
    assign done      = (state == S_DONE);
    assign m_data    = buf_data[rd_ptr];
    assign m_last    = m_valid & buf_last[rd_ptr];
    assign dbg_state = state;

    // Next-state selection for the drain sequencer.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: if (issue_last) state_nx = S_FLUSH;
            S_FLUSH: if (!inflight && (buf_count == 2'd0 || (buf_count == 2'd1 && pop)))
                         state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register, read counter, held address and in-flight tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rd_cnt        <= '0;
            addr_q        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nx;
            inflight      <= issue;
            inflight_last <= issue_last;
            if (state == S_DONE)
                rd_cnt <= '0;
            else if (issue)
                rd_cnt <= rd_cnt + 1'b1;
            if (issue)
                addr_q <= rd_cnt[AW-1:0];
        end
    end

    // Two-entry output FIFO fed by returning SRAM data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_data  <= '0;
            buf_last  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= rdata;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            buf_count <= buf_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // A push into a full buffer without a matching pop would drop a word.
    always_ff @(posedge clk) begin
        if (rst_n && push && !pop)
            assert (buf_count != 2'd2);
    end

endmodule
